// File: rtl/clk_pkg.sv
// Shared definitions for the digital clock time-setting sequencer.
// Contents:
//   state_t              - sequencer states (RUN, SET_HR, SET_MIN, SET_SEC)
//   FIELD_*              - codes presented on the 'field' output
//   HOUR_MAX/MINSEC_MAX  - decimal wrap limits of the BCD counters
//   next_state()         - state transition helper
//   field_of()           - maps a state to the field code it presents
//   mask_of()            - builds the per-digit blank mask for a field
package clk_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HR   = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam int HOUR_MAX   = 23;
    localparam int MINSEC_MAX = 59;

    // Leaving SET always wins over a select edge, and RUN ignores buttons,
    // so only a live SET state can step through the fields.
    function automatic state_t next_state(input state_t s, input logic set_en,
                                          input logic sel_edge);
        state_t n;
        n = s;
        case (s)
            RUN:     n = set_en ? SET_HR : RUN;
            SET_HR:  n = !set_en ? RUN : (sel_edge ? SET_MIN : SET_HR);
            SET_MIN: n = !set_en ? RUN : (sel_edge ? SET_SEC : SET_MIN);
            SET_SEC: n = !set_en ? RUN : (sel_edge ? SET_HR : SET_SEC);
            default: n = RUN;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] field_of(input state_t s);
        logic [1:0] f;
        case (s)
            SET_HR:  f = FIELD_HR;
            SET_MIN: f = FIELD_MIN;
            SET_SEC: f = FIELD_SEC;
            default: f = FIELD_NONE;
        endcase
        return f;
    endfunction

    // Both digits of the selected field follow the blink phase.
    function automatic logic [5:0] mask_of(input logic [1:0] f, input logic phase);
        logic [5:0] m;
        case (f)
            FIELD_HR:  m = {phase, phase, 4'b0000};
            FIELD_MIN: m = {2'b00, phase, phase, 2'b00};
            FIELD_SEC: m = {4'b0000, phase, phase};
            default:   m = 6'b000000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bcd2_cnt.sv
// Two-digit BCD up-counter that wraps from MAX back to 00.
// Ports:
//   clk50mhz - system clock
//   rst_n    - asynchronous active-low reset, clears q to 00
//   inc      - advance by one on this clock edge
//   q        - registered BCD value, [7:4] tens, [3:0] units
//   carry    - high in the cycle an increment wraps MAX -> 00, so a
//              neighbouring counter can advance on the same edge
module bcd2_cnt #(
    parameter int MAX = 59
) (
    input  logic       clk50mhz,
    input  logic       rst_n,
    input  logic       inc,
    output logic [7:0] q,
    output logic       carry
);

    localparam logic [3:0] MAX_TENS  = 4'(MAX / 10);
    localparam logic [3:0] MAX_UNITS = 4'(MAX % 10);

    logic at_max;

    assign at_max = (q[7:4] == MAX_TENS) && (q[3:0] == MAX_UNITS);
    assign carry  = inc && at_max;

    // Units roll 9 -> 0 into the tens digit; the full value wraps at MAX,
    // so the digits never leave the BCD range.
    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            q <= 8'h00;
        end else if (inc) begin
            if (at_max) begin
                q <= 8'h00;
            end else if (q[3:0] == 4'd9) begin
                q[3:0] <= 4'd0;
                q[7:4] <= q[7:4] + 4'd1;
            end else begin
                q[3:0] <= q[3:0] + 4'd1;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time register sequencer for the digital clock.
// RUN advances HH:MM:SS once per second; SET freezes time and lets the
// select/increment buttons pick and bump the hour, minute or second field.
// Ports:
//   clk50mhz   - system clock (CLK_HZ)
//   rst_n      - asynchronous active-low reset
//   set_en     - level, 1 = time-setting mode
//   btn_sel    - debounced level, rising edge selects the next field
//   btn_inc    - debounced level, rising edge increments the selected field
//   hour/min/sec - BCD time digits
//   blink_mask - 1 = blank digit, [5:4] hour, [3:2] min, [1:0] sec
//   field      - 0 none, 1 hour, 2 min, 3 sec
//   tick_1hz   - one-cycle pulse each RUN second
module time_set_ctrl
    import clk_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk50mhz,
    input  logic       rst_n,
    input  logic       set_en,
    input  logic       btn_sel,
    input  logic       btn_inc,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic [5:0] blink_mask,
    output logic [1:0] field,
    output logic       tick_1hz
);

    localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int HALF = (CLK_HZ / (2 * BLINK_HZ) > 0) ? CLK_HZ / (2 * BLINK_HZ) : 1;
    localparam int BW   = $clog2(HALF + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    field_nxt;
    logic [PW-1:0] presc;
    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic          sel_q;
    logic          inc_q;

    logic sel_edge;
    logic inc_edge;
    logic run_tick;
    logic inc_live;
    logic sec_inc;
    logic min_inc;
    logic hr_inc;
    logic sec_carry;
    logic min_carry;
    logic hr_carry_unused;

    assign sel_edge = btn_sel && !sel_q;
    assign inc_edge = btn_inc && !inc_q;

    // A second only elapses while staying in RUN; the cycle that enters SET
    // already counts as frozen.
    assign run_tick = (state == RUN) && !set_en && (presc == PRESC_LAST);

    // Edges are honoured only in a SET state that is not being left this cycle.
    assign inc_live = (state != RUN) && set_en && inc_edge;

    // Carries only ride on the RUN tick, so a SET increment never spills over.
    assign sec_inc = run_tick || (inc_live && (state == SET_SEC));
    assign min_inc = (run_tick && sec_carry) || (inc_live && (state == SET_MIN));
    assign hr_inc  = (run_tick && min_carry) || (inc_live && (state == SET_HR));

    assign state_nxt = next_state(state, set_en, sel_edge);
    assign field_nxt = field_of(state_nxt);

    bcd2_cnt #(.MAX(MINSEC_MAX)) u_sec (
        .clk50mhz (clk50mhz),
        .rst_n    (rst_n),
        .inc      (sec_inc),
        .q        (sec),
        .carry    (sec_carry)
    );

    bcd2_cnt #(.MAX(MINSEC_MAX)) u_min (
        .clk50mhz (clk50mhz),
        .rst_n    (rst_n),
        .inc      (min_inc),
        .q        (min),
        .carry    (min_carry)
    );

    bcd2_cnt #(.MAX(HOUR_MAX)) u_hour (
        .clk50mhz (clk50mhz),
        .rst_n    (rst_n),
        .inc      (hr_inc),
        .q        (hour),
        .carry    (hr_carry_unused)
    );

    // Sequencer state, prescaler, edge history and blink generator.
    // The prescaler sits at 0 outside RUN so the first tick after leaving
    // SET arrives a full second later. The blink counter restarts with the
    // phase cleared whenever the presented field changes, so a newly
    // selected field starts out visible; blink_mask is computed from the
    // next field/phase so it lines up with the registered field output.
    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            field      <= FIELD_NONE;
            presc      <= '0;
            tick_1hz   <= 1'b0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            blink_mask <= 6'b000000;
            sel_q      <= 1'b0;
            inc_q      <= 1'b0;
        end else begin
            state    <= state_nxt;
            field    <= field_nxt;
            sel_q    <= btn_sel;
            inc_q    <= btn_inc;
            tick_1hz <= run_tick;

            if ((state == RUN) && !set_en && !run_tick) begin
                presc <= presc + PW'(1);
            end else begin
                presc <= '0;
            end

            if (field_nxt != field) begin
                blink_cnt  <= '0;
                phase      <= 1'b0;
                blink_mask <= mask_of(field_nxt, 1'b0);
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt  <= '0;
                phase      <= !phase;
                blink_mask <= mask_of(field_nxt, !phase);
            end else begin
                blink_cnt  <= blink_cnt + BW'(1);
                blink_mask <= mask_of(field_nxt, phase);
            end
        end
    end

endmodule
